// File: rtl/instr_sequencer.sv
// instr_sequencer: 4-entry prefetch FIFO feeding a four-step instruction sequencer.
// An LDI word consumes the following stream word as its immediate operand.
// Optional HALT opcode (110) support is compiled in when INSTR_SEQ_HALT_EN is defined.
module instr_sequencer #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [2:0]  LDI_OP = 3'b101
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       run,
   input  logic [8:0] instr_data,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic [8:0] in,
   output logic [1:0] cont,
   output logic [8:0] immediate,
   output logic       busy,
   output logic       done
`ifdef INSTR_SEQ_HALT_EN
   ,
   output logic       halted
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef INSTR_SEQ_HALT_EN
   localparam logic [2:0] HALT_OP = 3'b110;
   typedef enum logic [1:0] {StIdle, StWaitImm, StExec, StHalt} state_e;
`else
   typedef enum logic [1:0] {StIdle, StWaitImm, StExec} state_e;
`endif

   // Prefetch FIFO storage and bookkeeping
   logic [8:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [8:0]    w_head;

   // Sequencer state and registered outputs
   state_e        r_state;
   state_e        w_state_d;
   logic [8:0]    r_in;
   logic [8:0]    w_in_d;
   logic [1:0]    r_cont;
   logic [1:0]    w_cont_d;
   logic [8:0]    r_imm;
   logic [8:0]    w_imm_d;
   logic          w_issue;

   assign w_full      = (r_count == (AW+1)'(DEPTH));
   assign w_empty     = (r_count == '0);
   // Ready depends only on the stored count, so a same-cycle pop never frees a full FIFO.
   assign instr_ready = ~w_full;
   assign w_push      = instr_valid & ~w_full;
   assign w_head      = r_mem[r_rptr];

   // FIFO data array; no reset needed since count gates every read
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= instr_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // Sequencer state register and registered outputs
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state <= StIdle;
         r_in    <= '0;
         r_cont  <= 2'b00;
         r_imm   <= '0;
      end else begin
         r_state <= w_state_d;
         r_in    <= w_in_d;
         r_cont  <= w_cont_d;
         r_imm   <= w_imm_d;
      end
   end

   // Next-state logic: step counting, immediate fetch and instruction issue
   always_comb begin
      w_state_d = r_state;
      w_in_d    = r_in;
      w_cont_d  = r_cont;
      w_imm_d   = r_imm;
      w_pop     = 1'b0;
      w_issue   = 1'b0;

      unique case (r_state)
         StIdle: begin
            w_cont_d = 2'b00;
            w_issue  = run & ~w_empty;
         end
         StWaitImm: begin
            // The immediate is taken regardless of run so an LDI never stalls half-issued.
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_imm_d   = w_head;
               w_state_d = StExec;
               w_cont_d  = 2'b00;
            end
         end
         StExec: begin
            if (r_cont == 2'b11) begin
               w_issue = run & ~w_empty;
               if (!w_issue) begin
                  w_state_d = StIdle;
                  w_cont_d  = 2'b00;
               end
            end else begin
               w_cont_d = r_cont + 2'd1;
            end
         end
`ifdef INSTR_SEQ_HALT_EN
         StHalt: begin
            w_cont_d = 2'b00;
         end
`endif
         default: begin
            w_state_d = StIdle;
            w_cont_d  = 2'b00;
         end
      endcase

      // Shared issue path for IDLE and the back-to-back wrap out of step 11
      if (w_issue) begin
         w_pop    = 1'b1;
         w_in_d   = w_head;
         w_cont_d = 2'b00;
         if (w_head[8:6] == LDI_OP) begin
            w_state_d = StWaitImm;
`ifdef INSTR_SEQ_HALT_EN
         end else if (w_head[8:6] == HALT_OP) begin
            w_state_d = StHalt;
`endif
         end else begin
            w_state_d = StExec;
         end
      end
   end

   assign in        = r_in;
   assign cont      = r_cont;
   assign immediate = r_imm;
   assign busy      = (r_state != StIdle);
   assign done      = (r_state == StExec) && (r_cont == 2'b11);
`ifdef INSTR_SEQ_HALT_EN
   assign halted    = (r_state == StHalt);
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: transaction-level reference model plus
// directed scenarios and a randomized phase.
module tb_instr_sequencer;

   localparam int unsigned DEPTH = 4;
`ifdef INSTR_SEQ_HALT_EN
   localparam bit HALT_MODEL = 1'b1;
`else
   localparam bit HALT_MODEL = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       run;
   logic [8:0] instr_data;
   logic       instr_valid;
   logic       instr_ready;
   logic [8:0] in;
   logic [1:0] cont;
   logic [8:0] immediate;
   logic       busy;
   logic       done;
`ifdef INSTR_SEQ_HALT_EN
   logic       halted;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   instr_sequencer #(
      .DEPTH (DEPTH),
      .LDI_OP(3'b101)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .run        (run),
      .instr_data (instr_data),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .in         (in),
      .cont       (cont),
      .immediate  (immediate),
      .busy       (busy),
      .done       (done)
`ifdef INSTR_SEQ_HALT_EN
      ,
      .halted     (halted)
`endif
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference model: queue of buffered words plus the instruction in flight.
   logic [8:0] q[$];
   logic [8:0] m_in   = '0;
   logic [8:0] m_imm  = '0;
   int         m_step = 0;
   bit         m_exec = 1'b0;
   bit         m_wait = 1'b0;
   bit         m_halt = 1'b0;

   always @(posedge clk) begin
      bit         pushed;
      logic [8:0] w;
      pushed = instr_valid && (q.size() < DEPTH);
      if (resetn) begin
         q.delete();
         m_in = '0; m_imm = '0; m_step = 0;
         m_exec = 1'b0; m_wait = 1'b0; m_halt = 1'b0;
      end else begin
         if (m_halt) begin
            // frozen until reset
         end else if (m_wait) begin
            if (q.size() > 0) begin
               m_imm  = q.pop_front();
               m_wait = 1'b0;
               m_exec = 1'b1;
               m_step = 0;
            end
         end else if (m_exec && m_step < 3) begin
            m_step++;
         end else begin
            m_exec = 1'b0;
            m_step = 0;
            if (run && q.size() > 0) begin
               w    = q.pop_front();
               m_in = w;
               if (w[8:6] == 3'b101) m_wait = 1'b1;
               else if (HALT_MODEL && w[8:6] == 3'b110) m_halt = 1'b1;
               else m_exec = 1'b1;
            end
         end
         if (pushed) q.push_back(instr_data);
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("in",          in,          m_in);
         check("cont",        cont,        m_step);
         check("immediate",   immediate,   m_imm);
         check("busy",        busy,        m_exec | m_wait | m_halt);
         check("done",        done,        m_exec && m_step == 3);
         check("instr_ready", instr_ready, q.size() < DEPTH);
`ifdef INSTR_SEQ_HALT_EN
         check("halted",      halted,      m_halt);
`endif
      end
   end

   initial begin
      bit found;
      logic [8:0] d;

      resetn = 1'b1; run = 1'b1; instr_valid = 1'b0; instr_data = '0;
      repeat (2) tick();
      chk_en = 1'b1;
      check("rst_in", in, 9'd0);
      check("rst_cont", cont, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", instr_ready, 1'b1);
      resetn = 1'b0;
      tick();

      // Single ALU-style word: issue latency and four steps
      instr_valid = 1'b1; instr_data = 9'b000_001_010;
      tick();
      instr_valid = 1'b0;
      tick();
      check("s1_in", in, 9'h00A);
      check("s1_cont0", cont, 2'b00);
      tick(); check("s1_cont1", cont, 2'b01);
      tick(); check("s1_cont2", cont, 2'b10); check("s1_nodone", done, 1'b0);
      tick(); check("s1_cont3", cont, 2'b11); check("s1_done", done, 1'b1);
      tick(); check("s1_idle", busy, 1'b0); check("s1_hold_in", in, 9'h00A);

      // LDI with a late immediate
      instr_valid = 1'b1; instr_data = 9'b101_011_000;
      tick();
      instr_valid = 1'b0;
      repeat (3) tick();
      check("s2_wait_busy", busy, 1'b1);
      check("s2_wait_cont", cont, 2'b00);
      check("s2_wait_in", in, 9'h158);
      instr_valid = 1'b1; instr_data = 9'd77;
      tick();
      instr_valid = 1'b0;
      tick();
      check("s2_imm", immediate, 9'd77);
      check("s2_cont0", cont, 2'b00);
      repeat (5) tick();
      check("s2_idle", busy, 1'b0);

      // Fill with run low, then drain back-to-back
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         instr_valid = 1'b1; instr_data = 9'h010 + 9'(i);
         tick();
      end
      check("s3_full", instr_ready, 1'b0);
      instr_valid = 1'b0;
      run = 1'b1;
      repeat (3) tick();
      check("s3_ready_back", instr_ready, 1'b1);
      repeat (16) tick();
      check("s3_last_in", in, 9'h013);

      // Drop run at step 01: instruction still completes
      instr_valid = 1'b1; instr_data = 9'h033;
      tick();
      instr_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (cont == 2'b01) found = 1'b1;
      end
      check("s5_reach_cont1", found, 1'b1);
      run = 1'b0;
      repeat (4) tick();
      check("s5_idle", busy, 1'b0);
      check("s5_in", in, 9'h033);
      run = 1'b1;

      // Reset mid-instruction with two words queued
      instr_valid = 1'b1; instr_data = 9'h041; tick();
      instr_data = 9'h042; tick();
      instr_data = 9'h043; tick();
      instr_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         if (cont == 2'b10) found = 1'b1;
         else tick();
      end
      check("s4_reach_cont2", found, 1'b1);
      resetn = 1'b1;
      tick();
      check("s4_cont", cont, 2'b00);
      check("s4_in", in, 9'd0);
      check("s4_ready", instr_ready, 1'b1);
      resetn = 1'b0;
      repeat (3) tick();
      check("s4_flushed", busy, 1'b0);

      // Opcode 110 followed by a normal word
      instr_valid = 1'b1; instr_data = 9'b110_000_000; tick();
      instr_data = 9'h00A; tick();
      instr_valid = 1'b0;
      repeat (12) tick();
`ifdef INSTR_SEQ_HALT_EN
      check("s6_halted", halted, 1'b1);
      check("s6_in", in, 9'h180);
`else
      check("s6_in", in, 9'h00A);
      check("s6_idle", busy, 1'b0);
`endif
      resetn = 1'b1; tick(); resetn = 1'b0;

      // Randomized traffic with occasional resets and run toggling
      for (int i = 0; i < 3000; i++) begin
         resetn      = ($urandom_range(299) == 0);
         run         = ($urandom_range(7) != 0);
         instr_valid = $urandom_range(1);
         d           = 9'($urandom_range(511));
         if (d[8:6] == 3'b110 && $urandom_range(15) != 0) d[8:6] = 3'b000;
         instr_data  = d;
         tick();
      end

      instr_valid = 1'b0;
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction fetch and step sequencer placed directly upstream of the control unit. It accepts 9-bit instruction words (`opcode[8:6]`, `rx[5:3]`, `ry[2:0]`) over a valid/ready stream into a 4-entry prefetch FIFO. It issues one instruction at a time on `in` and drives the 2-bit step counter `cont` through steps 00→01→10→11. For LDI (opcode 101), it fetches the following stream word as the immediate operand before execution starts.

## Interface
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥2.
- `LDI_OP`, 3'b101: opcode that consumes a second word as the immediate.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: reset, synchronous and active-high (asserted = 1), sampled on `clk`.
- `run` in 1: level enable; new instructions issue only while high.
- `instr_data` in 9: incoming instruction or immediate word.
- `instr_valid` in 1: `instr_data` is valid.
- `instr_ready` out 1: FIFO can accept a word; equals `!full`.
- `in` out 9: current instruction to the control unit (registered).
- `cont` out 2: current execution step (registered).
- `immediate` out 9: immediate operand of the current LDI (registered).
- `busy` out 1: high in WAIT_IMM, EXEC and HALT.
- `done` out 1: high for exactly the cycle in which `cont`==11.
- `halted` out 1: exists only with `HALT_EN` (see Configuration).

## Operation
- Push happens when `instr_valid && instr_ready`. Pop is internal. Order is strictly FIFO.
- A push and a pop in the same cycle are both performed; count is unchanged.
- There is no bypass: a word pushed into an empty FIFO is poppable no earlier than the next edge.
- When full, `instr_ready`=0 even if a pop occurs in the same cycle.
- States are IDLE, WAIT_IMM, EXEC and HALT (HALT only with `HALT_EN`).
- IDLE: `cont`=00 is held. If `run && !empty`, pop into `in`.
  - If opcode==`LDI_OP`, go to WAIT_IMM.
  - Otherwise go to EXEC with `cont`=00.
- WAIT_IMM: `cont`=00 is held and `in` is stable. When `!empty` (ignoring `run`), pop into `immediate` and go to EXEC with `cont`=00.
- EXEC: `cont` increments by 1 per clock through 00,01,10,11.
  - In the cycle with `cont`==11, `done`=1.
  - If `run && !empty` at that cycle, the next instruction is popped at the same edge. `in` updates and `cont` wraps to 00 (back-to-back issue, no gap).
  - Otherwise the block goes to IDLE with `cont`=00 and `in` unchanged.
- Deasserting `run` mid-EXEC or in WAIT_IMM does not abort; the current instruction completes.
- `immediate` holds its value until the next LDI loads it. Non-LDI instructions do not touch it.
- All opcodes other than `LDI_OP` (and 110 under `HALT_EN`) are treated identically: one word, four steps.

## Timing
- Reset values:
  - `in`=9'd0, `cont`=00, `immediate`=9'd0, `busy`=0, `done`=0, `halted`=0.
  - FIFO is empty, `instr_ready`=1, state is IDLE.
- Reset mid-operation flushes the FIFO and abandons the current instruction. Outputs return to reset values at the reset edge.
- Latency with the FIFO empty, state IDLE and `run`=1:
  - word accepted at edge t;
  - `in` updated with `cont`=00 after edge t+1;
  - `done` is high in the cycle after edge t+4.
- LDI adds at least one cycle for the immediate pop, plus any wait for the immediate word to arrive.
- Throughput is one non-LDI instruction per 4 clocks when the FIFO is non-empty.
- `cont`, `in` and `immediate` change only on `clk` edges, never combinationally.

## Configuration
- Macro: `INSTR_SEQ_HALT_EN`.
- Defined:
  - Opcode 110 popped from IDLE or at EXEC wrap enters HALT.
  - In HALT, `in` shows the HALT word, `cont`=00, `halted`=1 and `busy`=1.
  - No further pops occur, and the FIFO still accepts words until full.
  - Only `resetn` leaves HALT.
- Not defined:
  - The `halted` port and the HALT state are absent.
  - Opcode 110 executes as an ordinary four-step instruction.

## Test plan
- Reset with `run`=1, then push 9'b000_001_010 → `in`=9'h00A two edges after acceptance. `cont` runs 00,01,10,11, and `done`=1 only at 11, then IDLE.
- Push 9'b101_011_000 followed three cycles later by 9'd77 → state stays WAIT_IMM with `cont`=00 until 77 arrives. Then `immediate`=77 and four steps run.
- With `run`=0, push 5 words → the first 4 are accepted and `instr_ready`=0. Raise `run` → the instructions issue back-to-back with `cont` wrapping 11→00, and `instr_ready` returns to 1 after the first pop.
- Assert `resetn` while `cont`==10 with 2 words queued → next cycle `cont`=00, `in`=0, `instr_ready`=1, and the queued words are lost.
- Drop `run` at `cont`==01 → `cont` reaches 11, `done` pulses, and the block idles with `in` unchanged.
- With `INSTR_SEQ_HALT_EN`, push 9'b110_000_000 then 9'h00A → `halted`=1 and 9'h00A is never issued. Without the macro, both instructions execute.
